// File: rtl/a2d_sweep_sched.sv
// Sweeps the shared SPI A2D through ld_cell_lft, ld_cell_rght, steerPot, batt per request.
// Optional feature macro: BATT_DECIM_EN (battery converted once every BATT_DIV sweeps).
module a2d_sweep_sched #(
  parameter int GAP_CYC  = 2,
  parameter int BATT_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] wt_data,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        busy,
  output logic        sweep_done,
  output logic        ovrn,
  output logic [2:0]  state_dbg
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WAIT1 = 3'd2,
    GAP1  = 3'd3,
    READ  = 3'd4,
    WAIT2 = 3'd5,
    STORE = 3'd6,
    GAP2  = 3'd7
  } state_t;

  state_t          state, state_n;
  logic [1:0]      idx, idx_n;
  logic            pending;
  logic [GW-1:0]   gap_cnt;
  logic            gap_last;
  logic            last_chnl;

  // Sweep slot -> ADC128S channel number.
  function automatic logic [2:0] chnl_of(input logic [1:0] i);
    case (i)
      2'd0:    chnl_of = 3'd0;
      2'd1:    chnl_of = 3'd4;
      2'd2:    chnl_of = 3'd5;
      default: chnl_of = 3'd6;
    endcase
  endfunction

  assign gap_last = (gap_cnt == GAP_LAST);

`ifdef BATT_DECIM_EN
  localparam int BW = (BATT_DIV > 2) ? $clog2(BATT_DIV) : 1;
  logic [BW-1:0] batt_cnt;

  // Skipped-battery sweeps end after steerPot.
  assign last_chnl = (idx == 2'd3) || ((idx == 2'd2) && (batt_cnt != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          batt_cnt <= '0;
    else if (state == STORE && last_chnl) batt_cnt <= batt_cnt + 1'b1;
  end
`else
  assign last_chnl = (idx == 2'd3);
`endif

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    sweep_done = 1'b0;
    case (state)
      IDLE:  if (nxt || pending) state_n = CMD;
      CMD:   state_n = WAIT1;
      WAIT1: if (done) state_n = (GAP_CYC == 0) ? READ : GAP1;
      GAP1:  if (gap_last) state_n = READ;
      READ:  state_n = WAIT2;
      WAIT2: if (done) state_n = STORE;
      STORE: begin
        if (last_chnl) begin
          state_n    = IDLE;
          idx_n      = 2'd0;
          sweep_done = 1'b1;
        end else begin
          state_n = (GAP_CYC == 0) ? CMD : GAP2;
          idx_n   = idx + 2'd1;
        end
      end
      GAP2:    if (gap_last) state_n = CMD;
      default: state_n = IDLE;
    endcase
  end

  assign wrt       = (state == CMD) || (state == READ);
  assign busy      = (state != IDLE);
  assign ovrn      = busy && nxt && pending;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      pending   <= 1'b0;
      gap_cnt   <= '0;
      wt_data   <= 16'h0000;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == GAP1 || state == GAP2) gap_cnt <= gap_cnt + 1'b1;
      else                                gap_cnt <= '0;
      if (state == IDLE) pending <= 1'b0;
      else if (nxt)      pending <= 1'b1;
      // Command is loaded on entry to CMD and reused unchanged by READ.
      if (state_n == CMD) wt_data <= {2'b00, chnl_of(idx_n), 11'h000};
      if (state == WAIT2 && done) begin
        case (idx)
          2'd0:    lft_ld    <= rd_data[11:0];
          2'd1:    rght_ld   <= rd_data[11:0];
          2'd2:    steer_pot <= rd_data[11:0];
          default: batt      <= rd_data[11:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_a2d_sweep_sched.sv
// Bench for a2d_sweep_sched: ADC128S response model, wt_data/result scoreboard, reset and overrun cases.
module tb_a2d_sweep_sched;

  localparam int GAP = 2;
`ifdef BATT_DECIM_EN
  localparam int BDIV = 8;
  int mdl_bcnt;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        done_m = 1'b0;
  logic        inj_done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] wt_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        busy, sweep_done, ovrn;
  logic [2:0]  state_dbg;

  a2d_sweep_sched #(.GAP_CYC(GAP), .BATT_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .wt_data(wt_data),
    .done(done_m | inj_done), .rd_data(rd_data),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .busy(busy), .sweep_done(sweep_done), .ovrn(ovrn), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  logic [47:0] exp_res_q[$];
  logic [11:0] adc_val[8];
  logic [11:0] mdl_batt;
  logic [2:0]  prev_ch;
  logic [15:0] resp;
  int lat;
  int n_vec, n_err, sd_cnt, exp_sd, ovrn_cnt, wrt_cnt, since_done, wrt_par;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ADC128S: each response carries the result of the previous command's channel.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      lat    = 0;
      done_m = 1'b0;
    end else begin
      done_m = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          done_m  = 1'b1;
          rd_data = resp;
        end
      end
      if (wrt) begin
        resp    = {4'hA, adc_val[prev_ch]};
        prev_ch = wt_data[13:11];
        lat     = $urandom_range(1, 4);
      end
    end
  end

  // Monitor: pops expected commands on wrt and expected results on sweep_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      since_done = 0;
      wrt_par    = 0;
    end else begin
      if (done_m) since_done = 0;
      else        since_done++;
      if (wrt) begin
        wrt_cnt++;
        if (exp_q.size() == 0) check("wrt_unexpected", 64'd1, 64'd0);
        else                   check("wt_data", wt_data, exp_q.pop_front());
        if (wrt_par == 1) check("rd_spacing", since_done, GAP + 1);
        wrt_par ^= 1;
      end
      if (sweep_done) begin
        sd_cnt++;
        if (exp_res_q.size() == 0) check("sweep_unexpected", 64'd1, 64'd0);
        else check("results", {lft_ld, rght_ld, steer_pot, batt}, exp_res_q.pop_front());
      end
      if (ovrn) ovrn_cnt++;
    end
  end

  task automatic push_sweep();
    logic       conv;
    logic [2:0] chs[4];
    chs  = '{3'd0, 3'd4, 3'd5, 3'd6};
    conv = 1'b1;
`ifdef BATT_DECIM_EN
    conv     = (mdl_bcnt == 0);
    mdl_bcnt = (mdl_bcnt + 1) % BDIV;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < 3 || conv) begin
        exp_q.push_back({2'b00, chs[i], 11'h000});
        exp_q.push_back({2'b00, chs[i], 11'h000});
      end
    end
    if (conv) mdl_batt = adc_val[6];
    exp_res_q.push_back({adc_val[0], adc_val[4], adc_val[5], mdl_batt});
    exp_sd++;
  endtask

  task automatic pulse_nxt();
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
  endtask

  task automatic request_sweep();
    push_sweep();
    pulse_nxt();
  endtask

  task automatic wait_sweeps();
    for (int i = 0; i < 4000 && sd_cnt < exp_sd; i++) @(negedge clk);
    #1 check("sweep_count", sd_cnt, exp_sd);
  endtask

  initial begin
    int n5;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    prev_ch = 3'd0; mdl_batt = 12'h000; lat = 0;
    n_vec = 0; n_err = 0; sd_cnt = 0; exp_sd = 0; ovrn_cnt = 0; wrt_cnt = 0;
`ifdef BATT_DECIM_EN
    mdl_bcnt = 0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_results", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_wrt", wrt, 1'b0);
    check("rst_wt_data", wt_data, 16'h0000);
    check("rst_sweep_done", sweep_done, 1'b0);
    check("rst_ovrn", ovrn, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic sweep with the reference ADC values.
    adc_val[0] = 12'h300; adc_val[4] = 12'h2A0; adc_val[5] = 12'h800; adc_val[6] = 12'hC00;
    request_sweep();
    wait_sweeps();
    check("wrt_per_sweep", wrt_cnt, 8);

    // steerPot changes between sweeps.
    adc_val[5] = 12'hE00;
    request_sweep();
    wait_sweeps();
    check("steer_new", steer_pot, 12'hE00);
    check("lft_held", lft_ld, 12'h300);

    // Three requests in one sweep: one pending, one dropped.
    request_sweep();
    repeat (4) @(posedge clk);
    push_sweep();
    pulse_nxt();
    repeat (3) @(posedge clk);
    pulse_nxt();
    wait_sweeps();
    check("ovrn_count", ovrn_cnt, 1);

    // Request landing in the final STORE cycle is kept as pending.
    request_sweep();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sweep_done) break;
    end
    push_sweep();
    nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
    wait_sweeps();
    check("ovrn_after_edge", ovrn_cnt, 1);

    // Stray done in IDLE and in CMD is ignored.
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_busy", busy, 1'b0);
    check("idle_done_res", {lft_ld, rght_ld, steer_pot, batt},
          {adc_val[0], adc_val[4], adc_val[5], mdl_batt});
    push_sweep();
    pulse_nxt();
    inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    wait_sweeps();

    // Reset while waiting for the steerPot result.
    adc_val[0] = 12'h111; adc_val[4] = 12'h222; adc_val[5] = 12'h333; adc_val[6] = 12'h444;
    request_sweep();
    n5 = 0;
    for (int i = 0; i < 4000 && n5 < 2; i++) begin
      @(negedge clk);
      if (wrt && wt_data[13:11] == 3'd5) n5++;
    end
    check("find_chnl5_read", n5, 2);
    @(negedge clk);
    check("in_wait2", state_dbg, 3'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_res", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_wt", wt_data, 16'h0000);
    exp_q.delete();
    exp_res_q.delete();
    exp_sd   = sd_cnt;
    mdl_batt = 12'h000;
`ifdef BATT_DECIM_EN
    mdl_bcnt = 0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_idle", busy, 1'b0);
    request_sweep();
    wait_sweeps();

    // Random values over enough sweeps to wrap any battery divider.
    for (int s = 0; s < 10; s++) begin
      adc_val[0] = 12'($urandom_range(0, 4095));
      adc_val[4] = 12'($urandom_range(0, 4095));
      adc_val[5] = 12'($urandom_range(0, 4095));
      adc_val[6] = 12'($urandom_range(0, 4095));
      request_sweep();
      wait_sweeps();
    end

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_res_drained", exp_res_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
